shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
Sequential 8x8 unsigned shift-and-add multiplier: a controller FSM plus a small datapath (multiplicand, multiplier, accumulator, step counter).
- Sits between the debounced button pulses / operand registers and the seven-segment display logic of the board-level control unit.
- Accepts a one-cycle start pulse, computes over a fixed number of steps, presents a held 16-bit product with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), width of step counter output.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request pulse (typically a debouncer pulse output).
op_a  input  WIDTH  multiplicand, sampled on accepted start.
op_b  input  WIDTH  multiplier, sampled on accepted start.
busy  output  1  high in LOAD and CALC states.
done  output  1  one-cycle pulse, high only in DONE state.
product  output  2*WIDTH  result register, held until the next accepted start completes.
step_cnt  output  CNT_W  number of CALC steps executed in current/last operation.

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, product=0, step_cnt=0; internal mcand/mplier/acc=0.
- States: IDLE, LOAD, CALC, DONE (enum, one register).
- IDLE: start=1 at an edge -> LOAD; op_a/op_b captured at that same edge. start=0 -> stay.
- LOAD (1 cycle): mcand={WIDTH'0,op_a}, mplier=op_b, acc=0, step_cnt=0 -> CALC.
- CALC (one bit per cycle): if mplier[0], acc<=acc+mcand (2*WIDTH bits, no overflow possible); mcand<<=1; mplier>>=1; step_cnt+=1.
- CALC exit: after the step where step_cnt becomes WIDTH -> DONE; product<=final acc (including that step's add) at that same edge.
- DONE (1 cycle): done=1, busy=0 -> IDLE unconditionally.
- Latency (feature off): start sampled at edge 0; LOAD after edge 0; CALC after edges 1..WIDTH; DONE after edge WIDTH+1; done high WIDTH+1 cycles after start sampled (9 cycles for WIDTH=8).
- start in LOAD, CALC or DONE: ignored, not queued.
- start held high continuously: a new operation begins each time IDLE is re-entered.
- product unchanged from LOAD through CALC; only written on entry to DONE.
- op_a/op_b changes after capture have no effect on the running operation.
- Reset mid-operation: immediate abort, all state and outputs to reset values, no done pulse.
- Arithmetic is unsigned only. 0 * x = 0 still runs the full sequence unless the optional feature is enabled.

Optional Feature:
Macro: MULT_EARLY_TERM_EN
- Defined: CALC also exits to DONE after any step whose post-shift mplier==0, i.e. when no remaining multiplier bits are set. The minimum is one CALC step. step_cnt reports the actual number of steps executed, and product is identical to feature-off.
- Undefined: always exactly WIDTH CALC steps; step_cnt=WIDTH at DONE.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, LOAD, CALC, DONE};
  - localparam default WIDTH=8.
- No sub-module. The FSM and datapath are small enough for one module.
- start is expected from an existing debouncer pulse output and is not debounced here.

Test Plan:
- Reset release, no start -> busy=0, done=0, product=0x0000, step_cnt=0 indefinitely.
- op_a=13, op_b=11, start pulse -> done one cycle, exactly 9 cycles after start; product=0x008F; busy high for 9 cycles beforehand; step_cnt=8.
- op_a=0xFF, op_b=0xFF -> product=0xFE01. Second run 0x02*0x80 -> product=0x0100; product holds 0xFE01 until the second DONE.
- start re-pulsed during CALC with different operands -> ignored; result matches the first operands; no extra done.
- reset asserted at the 4th CALC cycle -> outputs zero immediately. A fresh start after release gives a correct product (0x05*0x06=0x001E).
- MULT_EARLY_TERM_EN defined:
  - op_a=0x37, op_b=0x01 -> done 2 cycles after start, product=0x0037, step_cnt=1.
  - op_b=0x00 -> product=0x0000, step_cnt=1.
  - op_b=0x80 -> step_cnt=8.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier controller.
package mult_pkg;

    // Default operand width in bits; the product is twice this wide.
    localparam int unsigned MULT_WIDTH = 8;

    // Controller states, held in a single state register.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    // Width of a counter that must be able to hold the value w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Request/result bundle between the board control logic and the multiplier.
// The master drives the start pulse and operands; the slave (the multiplier)
// returns status and the held product.
interface shift_add_mult_ctrl_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
);

    logic                 start;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     step_cnt;

    modport master (
        output start,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  product,
        input  step_cnt
    );

    modport slave (
        input  start,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output product,
        output step_cnt
    );

endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// One multiplier bit is consumed per CALC cycle; the product register is
// written only on entry to DONE and held until the next operation completes.
// Optional build macro MULT_EARLY_TERM_EN: leave CALC as soon as no multiplier
// bits remain set (at least one step is always executed).
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    shift_add_mult_ctrl_if.slave  bus
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     step_q, step_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shift;
    logic [CNT_W-1:0]     step_inc;
    logic                 last_step;

    // Per-step arithmetic: conditional add, shifted multiplier, step count,
    // and whether this step ends the CALC phase.
    always_comb begin
        acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;
        step_inc     = step_q + CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
        last_step    = (step_inc == CNT_W'(WIDTH)) || (mplier_shift == '0);
`else
        last_step    = (step_inc == CNT_W'(WIDTH));
`endif
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        step_d    = step_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Operands are captured on the accepting edge so later
                    // changes on op_a/op_b cannot disturb the operation.
                    state_d  = LOAD;
                    mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
                    mplier_d = bus.op_b;
                    acc_d    = '0;
                    step_d   = '0;
                end
            end
            LOAD: begin
                state_d = CALC;
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                step_d   = step_inc;
                if (last_step) begin
                    state_d   = DONE;
                    product_d = acc_sum;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            step_q    <= step_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        bus.busy     = (state_q == LOAD) || (state_q == CALC);
        bus.done     = (state_q == DONE);
        bus.product  = product_q;
        bus.step_cnt = step_q;
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl (WIDTH = 8).
// Stimulus pushes expected results; a monitor pops them on each done pulse.
module tb_shift_add_mult_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [15:0] prod;
        int          steps;
        longint      done_cyc;
    } exp_t;

    logic   clock;
    logic   reset;
    longint cyc;
    int     n_checks;
    int     n_errors;
    exp_t   sb[$];

    shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Steps the multiplier should take, from the multiplier operand alone.
    function automatic int model_steps(input int b);
`ifdef MULT_EARLY_TERM_EN
        int s;
        s = 1;
        for (int i = 0; i < W; i++) if (((b >> i) & 1) != 0) s = i + 1;
        return s;
`else
        return W;
`endif
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", 1, 0);
    endtask

    // Drive a one-cycle start; optionally record the expected outcome.
    task automatic issue(input int a, input int b, input bit expect_res);
        exp_t e;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = a[7:0];
        bus.op_b  = b[7:0];
        if (expect_res) begin
            e.prod     = 16'(a * b);
            e.steps    = model_steps(b);
            e.done_cyc = cyc + 1 + e.steps + 1;
            sb.push_back(e);
        end
        @(negedge clock);
        bus.start = 1'b0;
        // Scramble operands after capture; the running operation must ignore it.
        bus.op_a  = 8'($urandom);
        bus.op_b  = 8'($urandom);
    endtask

    // Monitor: compares every done pulse with the scoreboard head and checks
    // that the product holds its last completed value between pulses.
    initial begin : monitor
        exp_t        e;
        logic [15:0] held;
        int          busy_run;
        held     = '0;
        busy_run = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb.delete();
                held     = '0;
                busy_run = 0;
                check("reset_product", bus.product, 0);
            end else begin
                if (bus.busy) busy_run++;
                if (bus.done) begin
                    check("done_busy_low", bus.busy, 0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("product", bus.product, e.prod);
                        check("step_cnt", bus.step_cnt, e.steps);
                        check("done_cycle", cyc, e.done_cyc);
                        check("busy_cycles", busy_run, e.steps + 1);
                        held = e.prod;
                    end
                    busy_run = 0;
                end else begin
                    check("product_hold", bus.product, held);
                end
            end
        end
    end

    initial begin : stimulus
        int a;
        int b;
        int n;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Idle after reset: nothing moves.
        repeat (5) begin
            @(negedge clock);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
            check("idle_step_cnt", bus.step_cnt, 0);
        end

        // Directed products.
        wait_idle(); issue(13, 11, 1);
        wait_idle(); issue(8'hFF, 8'hFF, 1);
        wait_idle(); issue(8'h02, 8'h80, 1);

        // Second start during CALC must be ignored.
        wait_idle(); issue(8'h5A, 8'hC3, 1);
        repeat (3) @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = 8'h11;
        bus.op_b  = 8'h22;
        @(negedge clock);
        bus.start = 1'b0;

        // Reset during the 4th CALC cycle aborts with no done pulse.
        wait_idle(); issue(8'h77, 8'h99, 0);
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        check("abort_step_cnt", bus.step_cnt, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_idle(); issue(8'h05, 8'h06, 1);

        // Early-termination corner operands (full-length when the feature is off).
        wait_idle(); issue(8'h37, 8'h01, 1);
        wait_idle(); issue(8'h37, 8'h00, 1);
        wait_idle(); issue(8'h00, 8'h5C, 1);
        wait_idle(); issue(8'hA5, 8'h80, 1);

        // Randomized operations with random gaps; half use narrow multipliers.
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clock);
            issue(a, b, 1);
        end

        // Drain the scoreboard within a bounded time.
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
